// File: rtl/demux_5_hs_pkg.sv
// Shared definitions for the 5-lane demultiplexer; the lane encoding matches the
// 5-input result selector so both ends of the bus agree.
package demux_5_hs_pkg;

  localparam int unsigned DW_DEFAULT = 32;
  localparam int unsigned NUM_LANES  = 5;

  localparam logic [2:0] LANE1    = 3'd0;
  localparam logic [2:0] LANE2    = 3'd1;
  localparam logic [2:0] LANE3    = 3'd2;
  localparam logic [2:0] LANE4    = 3'd3;
  localparam logic [2:0] LANE5    = 3'd4;
  localparam logic [2:0] LANE_MAX = 3'd4;

  typedef enum logic {StEmpty, StHold} state_e;

  // Illegal codes map to no lane at all.
  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [2:0] sel);
    logic [NUM_LANES-1:0] oh;
    oh = '0;
    case (sel)
      LANE1:   oh = 5'b00001;
      LANE2:   oh = 5'b00010;
      LANE3:   oh = 5'b00100;
      LANE4:   oh = 5'b01000;
      LANE5:   oh = 5'b10000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_5_hs_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; used for the drop count.
module demux_5_hs_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/demux_5_hs.sv
// Registered 1-to-5 demultiplexer with valid/ready on the input and each lane.
// Single-entry skid-free pipeline: one word per cycle while the target lane is ready.
module demux_5_hs
  import demux_5_hs_pkg::*;
#(
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  logic [2:0]           in_choose,
  output logic [DW-1:0]        z1,
  output logic [DW-1:0]        z2,
  output logic [DW-1:0]        z3,
  output logic [DW-1:0]        z4,
  output logic [DW-1:0]        z5,
  output logic [NUM_LANES-1:0] out_valid,
  input  logic [NUM_LANES-1:0] out_ready,
  output logic                 err,
  output logic [CNT_W-1:0]     drop_cnt
);

  state_e               state_q, state_d;
  logic [2:0]           sel_q, sel_d;
  logic [DW-1:0]        z_q [NUM_LANES];
  logic                 err_q;

  logic                 full;
  logic [NUM_LANES-1:0] sel_oh;
  logic [NUM_LANES-1:0] in_oh;
  logic                 sel_ready;
  logic                 accept;
  logic                 acc_legal;
  logic                 acc_illegal;
  logic                 deliver;

  assign full        = (state_q == StHold);
  assign sel_oh      = lane_onehot(sel_q);
  assign in_oh       = lane_onehot(in_choose);
  // Ready bits of lanes other than the held one are deliberately ignored.
  assign sel_ready   = |(out_ready & sel_oh);
  assign in_ready    = !full || sel_ready;
  assign accept      = in_valid && in_ready;
  assign acc_legal   = accept && (in_choose <= LANE_MAX);
  assign acc_illegal = accept && (in_choose > LANE_MAX);
  assign deliver     = full && sel_ready;

  // An illegal accept while full implies delivery, so it always falls to StEmpty.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (acc_legal) begin
      state_d = StHold;
      sel_d   = in_choose;
    end else if (deliver) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      err_q   <= acc_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) z_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (acc_legal && in_oh[i]) z_q[i] <= in_data;
      end
    end
  end

  demux_5_hs_sat_counter #(
    .CNT_W(CNT_W)
  ) u_drop_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (acc_illegal),
    .cnt  (drop_cnt)
  );

  assign out_valid = full ? sel_oh : '0;
  assign err       = err_q;
  assign z1        = z_q[0];
  assign z2        = z_q[1];
  assign z3        = z_q[2];
  assign z4        = z_q[3];
  assign z5        = z_q[4];

endmodule

// File: tb/tb_demux_5_hs.sv
// Scoreboard bench for demux_5_hs: accepted words are queued with their lane and
// checked against lane outputs; err/drop_cnt/in_ready are tracked by a small model.
module tb_demux_5_hs;

  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 8;

  typedef struct {
    logic [2:0]    lane;
    logic [DW-1:0] data;
  } entry_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [2:0]       in_choose;
  logic [DW-1:0]    z1, z2, z3, z4, z5;
  logic [4:0]       out_valid;
  logic [4:0]       out_ready;
  logic             err;
  logic [CNT_W-1:0] drop_cnt;

  int checks;
  int errors;

  entry_t           sb_q[$];
  logic [DW-1:0]    zexp [5];
  logic             exp_err;
  logic [CNT_W-1:0] exp_drop;

  demux_5_hs #(
    .DW   (DW),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_choose(in_choose),
    .z1       (z1),
    .z2       (z2),
    .z3       (z3),
    .z4       (z4),
    .z5       (z5),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err      (err),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    for (int i = 0; i < 5; i++) zexp[i] = '0;
    exp_err  = 1'b0;
    exp_drop = '0;
  endtask

  always @(negedge rst_n) model_reset();

  // Sample mid-cycle, then advance the model to what the next rising edge should do.
  always @(negedge clk) begin
    logic [4:0] exp_ov;
    logic       exp_rdy;
    exp_ov  = (sb_q.size() != 0) ? (5'b00001 << sb_q[0].lane) : 5'b00000;
    exp_rdy = (sb_q.size() == 0) || out_ready[sb_q[0].lane];
    check("out_valid", DW'(out_valid), DW'(exp_ov));
    check("in_ready", DW'(in_ready), DW'(exp_rdy));
    check("err", DW'(err), DW'(exp_err));
    check("drop_cnt", DW'(drop_cnt), DW'(exp_drop));
    check("z1", z1, zexp[0]);
    check("z2", z2, zexp[1]);
    check("z3", z3, zexp[2]);
    check("z4", z4, zexp[3]);
    check("z5", z5, zexp[4]);
    if (sb_q.size() != 0) begin
      check("held_data", zexp[sb_q[0].lane], sb_q[0].data);
    end
    if (rst_n) begin
      exp_err = 1'b0;
      if ((sb_q.size() != 0) && out_ready[sb_q[0].lane]) void'(sb_q.pop_front());
      if (in_valid && exp_rdy) begin
        if (in_choose <= 3'd4) begin
          entry_t e;
          e.lane = in_choose;
          e.data = in_data;
          sb_q.push_back(e);
          zexp[in_choose] = in_data;
        end else begin
          exp_err = 1'b1;
          if (exp_drop != '1) exp_drop = exp_drop + 1'b1;
        end
      end
    end
  end

  task automatic step(input logic v, input logic [2:0] c, input logic [DW-1:0] d,
                      input logic [4:0] r);
    in_valid  = v;
    in_choose = c;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    model_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_choose = '0;
    in_data   = '0;
    out_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 3'd0, '0, 5'b11111);

    // Single legal word to lane 3.
    step(1, 3'd2, 32'hDEADBEEF, 5'b11111);
    step(0, 3'd0, '0, 5'b11111);
    step(0, 3'd0, '0, 5'b11111);
    check("z3_kept", z3, 32'hDEADBEEF);

    // Stall on lane 1 while a second word waits at the input.
    step(1, 3'd0, 32'h11, 5'b00000);
    for (int i = 0; i < 4; i++) step(1, 3'd1, 32'h22, 5'b00000);
    check("stall_in_ready", DW'(in_ready), DW'(0));
    step(1, 3'd1, 32'h22, 5'b00001);
    step(0, 3'd0, '0, 5'b00000);
    check("z2_after_stall", z2, 32'h22);
    check("ov_after_stall", DW'(out_valid), DW'(5'b00010));
    step(0, 3'd0, '0, 5'b00010);

    // Streaming across all lanes, one per cycle.
    for (int i = 0; i < 5; i++) step(1, 3'(i), DW'(i + 1), 5'b11111);
    step(0, 3'd0, '0, 5'b11111);
    step(0, 3'd0, '0, 5'b11111);
    check("stream_z5", z5, 32'd5);

    // Illegal select, then enough illegal words to saturate the counter.
    step(1, 3'd7, 32'hFF, 5'b11111);
    step(0, 3'd0, '0, 5'b11111);
    check("drop_one", DW'(drop_cnt), DW'(1));
    for (int i = 0; i < 300; i++) step(1, 3'(5 + (i % 3)), DW'(i), 5'b11111);
    step(0, 3'd0, '0, 5'b11111);
    check("drop_sat", DW'(drop_cnt), DW'(255));

    // Asynchronous reset while lane 4 holds a word.
    step(1, 3'd3, 32'hCAFE, 5'b00000);
    step(0, 3'd0, '0, 5'b00000);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_z4", z4, '0);
    check("rst_drop", DW'(drop_cnt), DW'(0));
    check("rst_err", DW'(err), DW'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 3'd0, '0, 5'b11111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
